// File: rtl/apb_demux_timeout_pkg.sv
// Shared types and helpers for the APB one-to-N demultiplexer.
// No timing of its own; used by the decoder and the demux top.
// No flow control here; pure declarations.
package apb_demux_timeout_pkg;

  localparam int MAX_AW = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  function automatic logic addr_hit(input logic [MAX_AW-1:0] addr,
                                    input logic [MAX_AW-1:0] base,
                                    input logic [MAX_AW-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/apb_demux_timeout_addr_decode.sv
// Address decoder: paddr -> one-hot slave select plus miss flag, lowest index wins.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of the address.
module apb_demux_timeout_addr_decode
  import apb_demux_timeout_pkg::*;
#(
  parameter int                            SLV_NUM    = 4,
  parameter int                            ADDR_WIDTH = 32,
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_BASE   = '0,
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_MASK   = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SLV_NUM-1:0]    sel,
  output logic                  miss
);

  // Walk from the top index down so the lowest hitting slave overrides any higher one.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (addr_hit(MAX_AW'(addr),
                   MAX_AW'(SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
                   MAX_AW'(SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        sel    = '0;
        sel[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_demux_timeout.sv
// APB4 one-to-N demux with decode-error and timeout responses; all outputs registered.
// Latency capture->up_pready: 1 cycle on decode miss, 3 + slave wait states on a mapped access.
// Backpressure: slave pready stretches ACCESS up to TIMEOUT cycles; new setups only sampled in IDLE.
module apb_demux_timeout
  import apb_demux_timeout_pkg::*;
#(
  parameter int                            SLV_NUM    = 4,
  parameter int                            ADDR_WIDTH = 32,
  parameter int                            DATA_WIDTH = 32,
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_BASE   = '0,
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_MASK   = '0,
  parameter int                            TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         up_paddr,
  input  logic [2:0]                    up_pprot,
  input  logic                          up_psel,
  input  logic                          up_penable,
  input  logic                          up_pwrite,
  input  logic [DATA_WIDTH-1:0]         up_pwdata,
  input  logic [DATA_WIDTH/8-1:0]       up_pstrb,
  output logic                          up_pready,
  output logic [DATA_WIDTH-1:0]         up_prdata,
  output logic                          up_pslverr,
  output logic [ADDR_WIDTH-1:0]         dn_paddr,
  output logic [2:0]                    dn_pprot,
  output logic                          dn_pwrite,
  output logic [DATA_WIDTH-1:0]         dn_pwdata,
  output logic [DATA_WIDTH/8-1:0]       dn_pstrb,
  output logic [SLV_NUM-1:0]            dn_psel,
  output logic                          dn_penable,
  input  logic [SLV_NUM-1:0]            dn_pready,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] dn_prdata,
  input  logic [SLV_NUM-1:0]            dn_pslverr,
  output logic                          evt_timeout,
  output logic                          evt_decerr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
  } req_t;

  state_t                state_q, state_nxt;
  req_t                  req_q;
  logic [SLV_NUM-1:0]    sel_q, dec_sel, psel_nxt;
  logic                  dec_miss, capture, timeout_hit;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic                  sel_rdy, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata, prdata_nxt;
  logic                  penable_nxt, pready_nxt, pslverr_nxt, evt_to_nxt, evt_de_nxt;

  apb_demux_timeout_addr_decode #(
    .SLV_NUM    (SLV_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr (up_paddr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  assign capture     = up_psel && !up_penable;
  assign sel_rdy     = |(dn_pready & sel_q);
  assign sel_err     = |(dn_pslverr & sel_q);
  // pready on the limit cycle is checked first, so a late ready still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < SLV_NUM; i++) begin
      if (sel_q[i]) sel_rdata |= dn_prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    psel_nxt    = '0;
    penable_nxt = 1'b0;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = '0;
    evt_to_nxt  = 1'b0;
    evt_de_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          if (dec_miss) begin
            state_nxt   = ST_RESP;
            pready_nxt  = 1'b1;
            pslverr_nxt = 1'b1;
            evt_de_nxt  = 1'b1;
          end else begin
            state_nxt = ST_SETUP;
            psel_nxt  = dec_sel;
          end
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        psel_nxt    = sel_q;
        penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_rdy) begin
          state_nxt   = ST_RESP;
          pready_nxt  = 1'b1;
          pslverr_nxt = sel_err;
          prdata_nxt  = req_q.write ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_nxt   = ST_RESP;
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
          evt_to_nxt  = 1'b1;
        end else begin
          psel_nxt    = sel_q;
          penable_nxt = 1'b1;
          if (cnt_q != {CW{1'b1}}) cnt_nxt = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      sel_q       <= '0;
      dn_psel     <= '0;
      dn_penable  <= 1'b0;
      up_pready   <= 1'b0;
      up_pslverr  <= 1'b0;
      up_prdata   <= '0;
      evt_timeout <= 1'b0;
      evt_decerr  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      dn_psel     <= psel_nxt;
      dn_penable  <= penable_nxt;
      up_pready   <= pready_nxt;
      up_pslverr  <= pslverr_nxt;
      up_prdata   <= prdata_nxt;
      evt_timeout <= evt_to_nxt;
      evt_decerr  <= evt_de_nxt;
      if (state_q == ST_IDLE && capture) begin
        req_q <= '{addr: up_paddr, prot: up_pprot, write: up_pwrite,
                   wdata: up_pwdata, strb: up_pstrb};
        sel_q <= dec_sel;
      end
    end
  end

  assign dn_paddr  = req_q.addr;
  assign dn_pprot  = req_q.prot;
  assign dn_pwrite = req_q.write;
  assign dn_pwdata = req_q.wdata;
  assign dn_pstrb  = req_q.strb;

endmodule

// File: tb/tb_apb_demux_timeout.sv
// Randomised bench for apb_demux_timeout against a transaction-level model of decode, latency and response.
module tb_apb_demux_timeout;

  localparam int SLV_NUM = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TMO     = 8;
  localparam logic [SLV_NUM*AW-1:0] BASE = {32'h0000_4000, 32'h0000_2000, 32'h0000_1000, 32'h0000_1000};
  localparam logic [SLV_NUM*AW-1:0] MASK = {32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_F800, 32'hFFFF_F000};

  logic                  clk, rst_n;
  logic [AW-1:0]         up_paddr;
  logic [2:0]            up_pprot;
  logic                  up_psel, up_penable, up_pwrite;
  logic [DW-1:0]         up_pwdata;
  logic [DW/8-1:0]       up_pstrb;
  logic                  up_pready, up_pslverr;
  logic [DW-1:0]         up_prdata;
  logic [AW-1:0]         dn_paddr;
  logic [2:0]            dn_pprot;
  logic                  dn_pwrite, dn_penable;
  logic [DW-1:0]         dn_pwdata;
  logic [DW/8-1:0]       dn_pstrb;
  logic [SLV_NUM-1:0]    dn_psel, dn_pready, dn_pslverr;
  logic [SLV_NUM*DW-1:0] dn_prdata;
  logic                  evt_timeout, evt_decerr;

  int n_vec = 0;
  int n_bad = 0;
  logic [AW-1:0] m_base [SLV_NUM];
  logic [AW-1:0] m_mask [SLV_NUM];

  apb_demux_timeout #(
    .SLV_NUM(SLV_NUM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_paddr(up_paddr), .up_pprot(up_pprot), .up_psel(up_psel), .up_penable(up_penable),
    .up_pwrite(up_pwrite), .up_pwdata(up_pwdata), .up_pstrb(up_pstrb),
    .up_pready(up_pready), .up_prdata(up_prdata), .up_pslverr(up_pslverr),
    .dn_paddr(dn_paddr), .dn_pprot(dn_pprot), .dn_pwrite(dn_pwrite), .dn_pwdata(dn_pwdata),
    .dn_pstrb(dn_pstrb), .dn_psel(dn_psel), .dn_penable(dn_penable),
    .dn_pready(dn_pready), .dn_prdata(dn_prdata), .dn_pslverr(dn_pslverr),
    .evt_timeout(evt_timeout), .evt_decerr(evt_decerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first slave whose masked window contains the address, -1 if none.
  function automatic int exp_slave(input logic [AW-1:0] a);
    for (int i = 0; i < SLV_NUM; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that ends the transfer.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input logic [DW/8-1:0] strb, input logic [2:0] prot, input int waits,
                         input logic serr, input logic [DW-1:0] sdata, input int rst_at,
                         input bit drop_psel);
    int es, exp_lat, exp_acc, acc, lat;
    logic [SLV_NUM-1:0] psel_seen, exp_sel, noise;
    logic exp_err, got_err, de_seen, to_seen;
    logic [DW-1:0] exp_rdata, got_rdata;
    bit done;
    es        = exp_slave(addr);
    exp_lat   = (es < 0) ? 1 : ((waits < TMO) ? 3 + waits : 2 + TMO);
    exp_acc   = (es < 0) ? 0 : ((waits < TMO) ? waits + 1 : TMO);
    exp_err   = (es < 0 || waits >= TMO) ? 1'b1 : serr;
    exp_rdata = (es < 0 || waits >= TMO || wr) ? '0 : sdata;
    exp_sel   = (es < 0) ? '0 : SLV_NUM'(1) << es;
    acc = 0; lat = 0; done = 0; psel_seen = '0; de_seen = 0; to_seen = 0;
    got_err = 0; got_rdata = '0;
    up_psel = 1'b1; up_penable = 1'b0; up_paddr = addr; up_pwrite = wr;
    up_pwdata = wdata; up_pstrb = strb; up_pprot = prot;
    dn_prdata  = {$urandom, $urandom, $urandom, $urandom};
    dn_pslverr = SLV_NUM'($urandom);
    if (es >= 0) begin
      dn_prdata[es*DW +: DW] = sdata;
      dn_pslverr[es]         = serr;
    end
    dn_pready = '0;
    @(posedge clk); #1;
    up_penable = 1'b1;
    for (int n = 1; n <= 30 && !done; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n == 1 && es >= 0) begin
        chk("setup_psel", 64'(dn_psel), 64'(exp_sel));
        chk("setup_penable", 64'(dn_penable), 64'(0));
        chk("dn_paddr", 64'(dn_paddr), 64'(addr));
        chk("dn_fields", {dn_pwrite, dn_pprot, dn_pstrb, dn_pwdata}, {wr, prot, strb, wdata});
      end
      psel_seen |= dn_psel;
      if (dn_penable && dn_psel != '0) acc++;
      if (rst_at != 0 && acc == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_psel", 64'(dn_psel), 64'(0));
        chk("rst_penable", 64'(dn_penable), 64'(0));
        chk("rst_pready", 64'(up_pready), 64'(0));
        up_psel = 1'b0; up_penable = 1'b0; dn_pready = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      // Selected slave answers after its wait states; idle slaves toggle pready as noise.
      noise     = SLV_NUM'($urandom) & ~dn_psel;
      dn_pready = ((dn_penable && acc == waits + 1) ? dn_psel : '0) | noise;
      if (drop_psel && n == 3) begin up_psel = 1'b0; up_penable = 1'b0; end
      if (evt_decerr) de_seen = 1'b1;
      if (evt_timeout) to_seen = 1'b1;
      if (up_pready) begin
        lat = n; got_rdata = up_prdata; got_err = up_pslverr; done = 1;
        chk("resp_psel", 64'(dn_psel), 64'(0));
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("access_cycles", 64'(acc), 64'(exp_acc));
    chk("psel_seen", 64'(psel_seen), 64'(exp_sel));
    chk("pslverr", 64'(got_err), 64'(exp_err));
    chk("prdata", 64'(got_rdata), 64'(exp_rdata));
    chk("evt_decerr", 64'(de_seen), 64'(es < 0));
    chk("evt_timeout", 64'(to_seen), 64'(es >= 0 && waits >= TMO));
    @(posedge clk); #1;
    dn_pready = '0;
    up_psel = 1'b0; up_penable = 1'b0;
    chk("pready_one_cycle", 64'(up_pready), 64'(0));
  endtask

  initial begin
    logic [AW-1:0] a;
    int w, gap;
    for (int i = 0; i < SLV_NUM; i++) begin
      m_base[i] = BASE[i*AW +: AW];
      m_mask[i] = MASK[i*AW +: AW];
    end
    rst_n = 1'b0; up_psel = 1'b0; up_penable = 1'b0; up_paddr = '0; up_pprot = '0;
    up_pwrite = 1'b0; up_pwdata = '0; up_pstrb = '0;
    dn_pready = '0; dn_prdata = '0; dn_pslverr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_up", {61'd0, up_pready, up_pslverr, evt_timeout}, 64'(0));
    chk("reset_prdata", 64'(up_prdata), 64'(0));
    chk("reset_dn", {59'd0, dn_psel, dn_penable}, 64'(0));
    chk("reset_evt_decerr", 64'(evt_decerr), 64'(0));
    chk("reset_dn_paddr", 64'(dn_paddr), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_xfer(32'h2004, 1'b0, 32'h0, 4'hF, 3'd0, 2, 1'b0, 32'hDEADBEEF, 0, 0);
    do_xfer(32'h9000, 1'b1, 32'h1234_5678, 4'h3, 3'd2, 0, 1'b0, 32'h0, 0, 0);
    do_xfer(32'h2010, 1'b0, 32'h0, 4'h0, 3'd1, 40, 1'b0, 32'hCAFE_F00D, 0, 0);
    do_xfer(32'h2010, 1'b0, 32'h0, 4'h0, 3'd1, TMO, 1'b0, 32'hCAFE_F00D, 0, 0);
    do_xfer(32'h4008, 1'b0, 32'h0, 4'hF, 3'd3, TMO - 1, 1'b0, 32'h5555_AAAA, 0, 0);
    do_xfer(32'h1004, 1'b0, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'h0BAD_C0DE, 0, 0);
    do_xfer(32'h7FFC, 1'b1, 32'hA5A5_5A5A, 4'h5, 3'd7, 1, 1'b1, 32'hFFFF_FFFF, 0, 0);
    do_xfer(32'h2000, 1'b0, 32'h0, 4'hF, 3'd0, 100, 1'b0, 32'h1111_2222, 3, 0);
    do_xfer(32'h1008, 1'b0, 32'h0, 4'hF, 3'd0, 1, 1'b0, 32'h3333_4444, 0, 0);
    do_xfer(32'h2020, 1'b1, 32'h7777_8888, 4'hC, 3'd0, 3, 1'b0, 32'h9999_0000, 0, 1);

    for (int t = 0; t < 160; t++) begin
      a = {16'h0, 4'($urandom_range(0, 9)), 12'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:16] = 16'($urandom);
      w = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 11) : $urandom_range(0, 3);
      do_xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), w, 1'($urandom_range(0, 3) == 0),
              $urandom, 0, $urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
